// File: rtl/axi4_stream_pkg.sv
// Shared AXI4-Stream types, FSM states and helpers for the packet datapath blocks.
// Exports: axi4_stream_word_t (canonical beat layout), len_prepend_state_t, tkeep_bytes().
// Modules that need other bus widths pass their own word type through a type parameter.
package axi4_stream_pkg;

  localparam int AXIS_DEF_DATA_W = 32;
  localparam int AXIS_DEF_USER_W = 1;
  localparam int AXIS_DEF_DEST_W = 1;
  localparam int AXIS_DEF_ID_W   = 1;

  // Widest tkeep the byte-count helper accepts (1024-bit tdata).
  localparam int KEEP_MAX_W = 128;

  typedef struct packed {
    logic [AXIS_DEF_DATA_W-1:0]   tdata;
    logic [AXIS_DEF_DATA_W/8-1:0] tstrb;
    logic [AXIS_DEF_DATA_W/8-1:0] tkeep;
    logic                         tlast;
    logic [AXIS_DEF_USER_W-1:0]   tuser;
    logic [AXIS_DEF_DEST_W-1:0]   tdest;
    logic [AXIS_DEF_ID_W-1:0]     tid;
  } axi4_stream_word_t;

  typedef enum logic [0:0] {
    S_HDR     = 1'b0,
    S_PAYLOAD = 1'b1
  } len_prepend_state_t;

  // Bytes carried by a beat: index of the highest set tkeep bit plus one.
  // Holes below the top byte are counted as present; tkeep == 0 gives 0.
  function automatic logic [7:0] tkeep_bytes(input logic [KEEP_MAX_W-1:0] keep);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if (keep[i]) n = 8'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave modports.
// Signals: tvalid/tready handshake, tdata, tstrb, tkeep, tlast, tuser, tdest, tid.
// Widths are set per instance; both ends of a link must use the same parameters.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TID_WIDTH-1:0]     tid;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_pipe_reg.sv
// Single-stage valid/ready register holding one beat of type word_t.
// Latency 1 cycle; accepts a new beat every cycle when the downstream drains it.
// Backpressure: in_rdy = !out_vld || out_rdy; contents held stable while stalled.
// Ports: clk_i/rst_n_i, in_vld/in_rdy/in_dat (upstream), out_vld/out_rdy/out_dat (downstream).
module axi4_stream_pipe_reg
  import axi4_stream_pkg::*;
#(
  parameter type word_t = axi4_stream_word_t
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  in_vld,
  output logic  in_rdy,
  input  word_t in_dat,
  output logic  out_vld,
  input  logic  out_rdy,
  output word_t out_dat
);

  logic  vld_q, vld_d;
  word_t dat_q, dat_d;

  assign in_rdy = !vld_q || out_rdy;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_rdy) begin
      vld_d = in_vld;
      if (in_vld) dat_d = in_dat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/axi4_stream_len_prepend.sv
// Prepends a byte-length header beat to each stored packet and checks the length.
// Latency 1 cycle (header visible the cycle after pkt_i.tvalid); N+1 cycles per N-beat packet.
// Backpressure: pkt_o.tready low stalls the output register and, through it, pkt_i.tready.
// Ports: clk_i, rst_n_i, pkt_size_i (length of head packet), pkt_i (slave), pkt_o (master),
//        len_err_o (1-cycle pulse on length mismatch), pkts_sent_o (wrapping packet count).
module axi4_stream_len_prepend
  import axi4_stream_pkg::*;
#(
  parameter int TDATA_WIDTH    = 32,
  parameter int TUSER_WIDTH    = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TID_WIDTH      = 1,
  parameter int PKT_SIZE_WIDTH = 5,
  parameter int HDR_TUSER      = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [PKT_SIZE_WIDTH:0] pkt_size_i,
  axi4_stream_if.slave            pkt_i,
  axi4_stream_if.master           pkt_o,
  output logic                    len_err_o,
  output logic [15:0]             pkts_sent_o
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int SZ_W   = PKT_SIZE_WIDTH + 1;
  localparam logic [SZ_W-1:0] BEAT_BYTES = SZ_W'(KEEP_W);

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] tdata;
    logic [KEEP_W-1:0]      tstrb;
    logic [KEEP_W-1:0]      tkeep;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TID_WIDTH-1:0]   tid;
  } word_t;

  len_prepend_state_t state_q, state_d;
  logic [SZ_W-1:0]    size_q, size_d;
  logic [SZ_W-1:0]    cnt_q, cnt_d;
  logic               len_err_q, len_err_d;
  logic [15:0]        pkts_sent_q, pkts_sent_d;

  logic               slot_free;
  logic               pipe_in_vld;
  word_t              pipe_in_dat;
  logic               pipe_out_vld;
  word_t              pipe_out_dat;
  logic               in_tready;
  word_t              head_dat;
  word_t              hdr_dat;
  logic [SZ_W-1:0]    last_bytes;
  logic [SZ_W-1:0]    total;

  always_comb begin
    head_dat.tdata = pkt_i.tdata;
    head_dat.tstrb = pkt_i.tstrb;
    head_dat.tkeep = pkt_i.tkeep;
    head_dat.tlast = pkt_i.tlast;
    head_dat.tuser = pkt_i.tuser;
    head_dat.tdest = pkt_i.tdest;
    head_dat.tid   = pkt_i.tid;

    // Header routing follows the packet it describes.
    hdr_dat.tdata  = TDATA_WIDTH'(pkt_size_i);
    hdr_dat.tstrb  = '1;
    hdr_dat.tkeep  = '1;
    hdr_dat.tlast  = 1'b0;
    hdr_dat.tuser  = TUSER_WIDTH'(HDR_TUSER);
    hdr_dat.tdest  = pkt_i.tdest;
    hdr_dat.tid    = pkt_i.tid;
  end

  // Count and compare at the size-word width; overflow wraps on purpose.
  assign last_bytes = SZ_W'(tkeep_bytes(KEEP_MAX_W'(pkt_i.tkeep)));
  assign total      = cnt_q + last_bytes;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    len_err_d   = 1'b0;
    pkts_sent_d = pkts_sent_q;
    pipe_in_vld = 1'b0;
    pipe_in_dat = head_dat;
    in_tready   = 1'b0;

    case (state_q)
      S_HDR: begin
        // The head beat is only peeked at here; it is consumed in S_PAYLOAD.
        pipe_in_vld = pkt_i.tvalid;
        pipe_in_dat = hdr_dat;
        if (pkt_i.tvalid && slot_free) begin
          size_d  = pkt_size_i;
          cnt_d   = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        in_tready   = slot_free;
        pipe_in_vld = pkt_i.tvalid;
        if (pkt_i.tvalid && slot_free) begin
          if (pkt_i.tlast) begin
            len_err_d   = (total != size_q);
            pkts_sent_d = pkts_sent_q + 16'd1;
            state_d     = S_HDR;
          end else begin
            cnt_d = cnt_q + BEAT_BYTES;
          end
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_HDR;
      size_q      <= '0;
      cnt_q       <= '0;
      len_err_q   <= 1'b0;
      pkts_sent_q <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      len_err_q   <= len_err_d;
      pkts_sent_q <= pkts_sent_d;
    end
  end

  axi4_stream_pipe_reg #(
    .word_t (word_t)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .in_vld  (pipe_in_vld),
    .in_rdy  (slot_free),
    .in_dat  (pipe_in_dat),
    .out_vld (pipe_out_vld),
    .out_rdy (pkt_o.tready),
    .out_dat (pipe_out_dat)
  );

  assign pkt_i.tready = in_tready;

  assign pkt_o.tvalid = pipe_out_vld;
  assign pkt_o.tdata  = pipe_out_dat.tdata;
  assign pkt_o.tstrb  = pipe_out_dat.tstrb;
  assign pkt_o.tkeep  = pipe_out_dat.tkeep;
  assign pkt_o.tlast  = pipe_out_dat.tlast;
  assign pkt_o.tuser  = pipe_out_dat.tuser;
  assign pkt_o.tdest  = pipe_out_dat.tdest;
  assign pkt_o.tid    = pipe_out_dat.tid;

  assign len_err_o   = len_err_q;
  assign pkts_sent_o = pkts_sent_q;

endmodule
